// File: rtl/gate_truth_scanner_if.sv
// Scanner <-> gate-under-test bundle: start/busy/done handshake plus gate drive and result.
// Compare ports exist only when GATE_SCAN_CHECK_EN is defined.
interface gate_truth_scanner_if;
  logic       start;
  logic [1:0] mask_in;
  logic       gate_result;
  logic       gate_in1;
  logic       gate_in2;
  logic [1:0] gate_mask;
  logic       busy;
  logic       done;
  logic [3:0] truth_table;
`ifdef GATE_SCAN_CHECK_EN
  logic [3:0] expected;
  logic       pass;
  logic       fail;

  modport master (
    input  start, mask_in, gate_result, expected,
    output gate_in1, gate_in2, gate_mask, busy, done, truth_table, pass, fail
  );
  modport slave (
    output start, mask_in, gate_result, expected,
    input  gate_in1, gate_in2, gate_mask, busy, done, truth_table, pass, fail
  );
`else
  modport master (
    input  start, mask_in, gate_result,
    output gate_in1, gate_in2, gate_mask, busy, done, truth_table
  );
  modport slave (
    output start, mask_in, gate_result,
    input  gate_in1, gate_in2, gate_mask, busy, done, truth_table
  );
`endif
endinterface

// File: rtl/gate_truth_scanner.sv
// Walks a 2-input bubble-mask gate through all four input vectors and builds its truth table.
// Optional GATE_SCAN_CHECK_EN adds a registered pass/fail compare against an expected table.
module gate_truth_scanner #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_WIDTH     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  gate_truth_scanner_if.master  bus
);

  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           index_q, index_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [1:0]           vec_q, vec_d;
  logic [1:0]           mask_q, mask_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           tt_q, tt_d;
`ifdef GATE_SCAN_CHECK_EN
  logic [3:0]           exp_q, exp_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
`endif

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      index_q   <= 2'd0;
      counter_q <= '0;
      vec_q     <= 2'd0;
      mask_q    <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tt_q      <= 4'd0;
`ifdef GATE_SCAN_CHECK_EN
      exp_q     <= 4'd0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      counter_q <= counter_d;
      vec_q     <= vec_d;
      mask_q    <= mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tt_q      <= tt_d;
`ifdef GATE_SCAN_CHECK_EN
      exp_q     <= exp_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    counter_d = counter_q;
    vec_d     = vec_q;
    mask_d    = mask_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tt_d      = tt_q;
`ifdef GATE_SCAN_CHECK_EN
    exp_d     = exp_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mask_d    = bus.mask_in;
          index_d   = 2'd0;
          counter_d = '0;
          vec_d     = 2'd0;
          busy_d    = 1'b1;
          state_d   = DRIVE;
`ifdef GATE_SCAN_CHECK_EN
          exp_d     = bus.expected;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
`endif
        end
      end
      DRIVE: begin
        counter_d = counter_q + CNT_WIDTH'(1);
        if (counter_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        tt_d[index_q] = bus.gate_result;
        if (index_q == 2'd3) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef GATE_SCAN_CHECK_EN
          pass_d  = (tt_d == exp_q);
          fail_d  = (tt_d != exp_q);
`endif
        end else begin
          index_d   = index_q + 2'd1;
          vec_d     = index_q + 2'd1;
          counter_d = '0;
          state_d   = DRIVE;
        end
      end
      DONE: begin
        vec_d   = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gate_in1    = vec_q[0];
  assign bus.gate_in2    = vec_q[1];
  assign bus.gate_mask   = mask_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
`ifdef GATE_SCAN_CHECK_EN
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
`endif

endmodule

// File: tb/tb_gate_truth_scanner.sv
// Directed bench: scanner drives a modelled bubble-mask AND gate; checks tables, latency and aborts.
module tb_gate_truth_scanner;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  gate_truth_scanner_if bus ();

  gate_truth_scanner #(.SETTLE_CYCLES(2), .CNT_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Gate under test: AND with per-input bubbles
  assign bus.gate_result = (bus.gate_in1 ^ bus.gate_mask[0]) & (bus.gate_in2 ^ bus.gate_mask[1]);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full scan; edge 1 is the accepting edge, done expected on edge 13
  task automatic scan(input string tag, input logic [1:0] m, input logic [3:0] exp,
                      input bit toggle, input bit poke);
    int done_edge;
    int busy_cnt;
    int mask_bad;
    done_edge = 0;
    busy_cnt  = 0;
    mask_bad  = 0;
    bus.mask_in = m;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.gate_mask !== m) mask_bad++;
    for (int e = 2; e <= 30 && done_edge == 0; e++) begin
      if (toggle) bus.mask_in = ~bus.mask_in;
      bus.start = poke && (e == 5);
      step();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.busy === 1'b1 && bus.gate_mask !== m) mask_bad++;
      if (bus.done === 1'b1) done_edge = e;
    end
    bus.start = 1'b0;
    check({tag, "_done_edge"}, 8'(done_edge), 8'd13);
    check({tag, "_busy_cycles"}, 8'(busy_cnt), 8'd12);
    check({tag, "_mask_frozen"}, 8'(mask_bad), 8'd0);
    check({tag, "_truth_table"}, 8'(bus.truth_table), 8'(exp));
    check({tag, "_busy_at_done"}, 8'(bus.busy), 8'd0);
    step();
    check({tag, "_done_pulse"}, 8'(bus.done), 8'd0);
    check({tag, "_inputs_idle"}, {6'd0, bus.gate_in2, bus.gate_in1}, 8'd0);
    step();
    step();
    check({tag, "_no_requeue"}, 8'(bus.busy), 8'd0);
  endtask

  initial begin
    int seen;
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.mask_in = 2'b00;
`ifdef GATE_SCAN_CHECK_EN
    bus.expected = 4'b0000;
`endif
    step();
    step();
    check("rst_busy", 8'(bus.busy), 8'd0);
    check("rst_done", 8'(bus.done), 8'd0);
    check("rst_tt", 8'(bus.truth_table), 8'd0);
    check("rst_in", {6'd0, bus.gate_in2, bus.gate_in1}, 8'd0);
    check("rst_mask", 8'(bus.gate_mask), 8'd0);
    reset = 1'b0;
    step();

    scan("and", 2'b00, 4'b1000, 1'b0, 1'b0);
    scan("nor", 2'b11, 4'b0001, 1'b0, 1'b0);
    scan("mask01_toggle", 2'b01, 4'b0100, 1'b1, 1'b0);
    scan("start_poke", 2'b00, 4'b1000, 1'b0, 1'b1);

    // Abort a scan with reset in its seventh cycle
    bus.mask_in = 2'b11;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (6) step();
    check("pre_abort_busy", 8'(bus.busy), 8'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 8'(bus.busy), 8'd0);
    check("abort_done", 8'(bus.done), 8'd0);
    check("abort_tt", 8'(bus.truth_table), 8'd0);
    check("abort_in", {6'd0, bus.gate_in2, bus.gate_in1}, 8'd0);
    check("abort_mask", 8'(bus.gate_mask), 8'd0);
    step();
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("abort_no_done", 8'(seen), 8'd0);
    scan("after_reset", 2'b01, 4'b0100, 1'b0, 1'b0);

    // Start held high: re-accepted on the first IDLE cycle after DONE
    bus.mask_in = 2'b00;
    bus.start   = 1'b1;
    step();
    repeat (12) step();
    check("held_done", 8'(bus.done), 8'd1);
    step();
    check("held_idle", 8'(bus.busy), 8'd0);
    step();
    check("held_reaccept", 8'(bus.busy), 8'd1);
    bus.start = 1'b0;
    repeat (14) step();
    check("held_finished", 8'(bus.busy), 8'd0);
    check("held_tt", 8'(bus.truth_table), 8'b1000);

`ifdef GATE_SCAN_CHECK_EN
    bus.expected = 4'b1000;
    scan("chk_match", 2'b00, 4'b1000, 1'b0, 1'b0);
    check("chk_pass_hi", 8'(bus.pass), 8'd1);
    check("chk_fail_lo", 8'(bus.fail), 8'd0);
    bus.expected = 4'b1001;
    bus.mask_in  = 2'b00;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    check("chk_clear_pass", 8'(bus.pass), 8'd0);
    check("chk_clear_fail", 8'(bus.fail), 8'd0);
    repeat (12) step();
    check("chk_mis_pass", 8'(bus.pass), 8'd0);
    check("chk_mis_fail", 8'(bus.fail), 8'd1);
    repeat (5) step();
    check("chk_fail_hold", 8'(bus.fail), 8'd1);
    bus.expected = 4'b1000;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    check("chk_fail_cleared", 8'(bus.fail), 8'd0);
    repeat (14) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_scanner.md
Name: gate_truth_scanner

Overview:
- Sequencer that exercises one 2-input combinational gate instance with bubble-mask configuration, such as the team's AND gate.
- Drives the gate's two inputs and mask through all four input combinations, waits a settle interval, then samples the result.
- Assembles a 4-bit truth table and reports completion with a start/busy/done handshake.
- Sits beside the gate in the tile as a self-test and characterisation controller.

Parameters:
- SETTLE_CYCLES, 2, cycles the input vector is held before sampling. Legal range 1..15.
- CNT_WIDTH, 4, width of the settle counter. Must satisfy 2^CNT_WIDTH > SETTLE_CYCLES.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a scan. Sampled only in IDLE.
- mask_in  input  2  bubble mask to apply during the scan. Latched when start is accepted.
- gate_result  input  1  result output of the gate under test.
- gate_in1  output  1  drives gate input1.
- gate_in2  output  1  drives gate input2.
- gate_mask  output  2  drives the gate bubble configuration (bit0 applies to input1, bit1 to input2).
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the truth table is valid.
- truth_table  output  4  bit k = sampled result for input vector {gate_in2,gate_in1} = k.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: all registers clear immediately on reset.
  - gate_in1 = 0, gate_in2 = 0, gate_mask = 0.
  - busy = 0, done = 0, truth_table = 0.
  - state = IDLE, index = 0, counter = 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - busy = 0. Outputs hold their last values.
  - On start = 1: latch mask_in into gate_mask, set index = 0, counter = 0, and go to DRIVE.
  - truth_table is not cleared on start. Bits are overwritten as sampled.
- DRIVE:
  - {gate_in2,gate_in1} = index. busy = 1.
  - counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle):
  - Inputs still equal index.
  - On the clock edge leaving SAMPLE, truth_table[index] <= gate_result.
  - If index == 3, go to DONE. Otherwise index <= index+1, counter <= 0, and go to DRIVE.
  - index is 2 bits and never wraps during a scan; the transition to DONE happens first.
- DONE (one cycle):
  - done = 1, busy = 0. Return to IDLE.
  - gate_in1/gate_in2 return to 0 on entering IDLE.
- Latency:
  - Each vector takes SETTLE_CYCLES + 1 cycles.
  - done is asserted exactly 1 + 4*(SETTLE_CYCLES+1) cycles after the edge that accepts start. With the default, this is 13 cycles.
- Boundary conditions:
  - start while busy (DRIVE, SAMPLE or DONE) is ignored; there is no queueing.
  - start held high continuously: a new scan is accepted on the first IDLE cycle after DONE.
  - mask_in changes mid-scan have no effect; gate_mask stays frozen until the next accept.
  - Reset mid-scan aborts immediately. All outputs return to their reset values and no done pulse is produced.
  - gate_result is sampled only in SAMPLE and ignored in all other states.

Optional Feature:
- Macro: GATE_SCAN_CHECK_EN.
- When defined, the block adds:
  - input expected (4 bits), latched with mask_in on start;
  - outputs pass and fail (1 bit each), both registered.
- pass and fail update in the DONE cycle: pass = (truth_table == expected), and fail is its complement.
- pass and fail hold until the next accept. They clear to 0 on start acceptance and on reset.
- When not defined, these ports are absent and there is no compare logic.

Test Plan:
- Reset, then start with mask_in=2'b00 on a plain AND gate, SETTLE_CYCLES=2 -> done 13 cycles after accept; truth_table=4'b1000; busy high 12 cycles.
- mask_in=2'b11 -> gate_mask=2'b11 during the scan; truth_table=4'b0001 (NOR behaviour).
- mask_in=2'b01 -> truth_table=4'b0100; toggling mask_in mid-scan leaves gate_mask=2'b01 and the same result.
- Pulse start during cycle 5 of a running scan -> ignored; exactly one done pulse; the next scan only runs after a fresh start in IDLE.
- Assert reset at cycle 7 of a scan -> busy, done, truth_table, gate_in1/2 and gate_mask all 0 in the same cycle; no done pulse; a later start rescans correctly.
- With GATE_SCAN_CHECK_EN: mask 00 and expected 4'b1000 -> pass=1, fail=0. expected 4'b1001 -> pass=0, fail=1, held until the next start.
